// File: rtl/rf_wb_arbiter.sv
// Write-side front end of the 32x32 register file: arbitrates pipeline (A) and long-latency (B)
// writebacks onto one registered rf write port, tracks busy regs, and bypasses the write in flight.
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_waddr,
  input  logic [31:0] a_wdata,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_waddr,
  input  logic [31:0] b_wdata,
  output logic        b_ready,
  input  logic        sb_set,
  input  logic [4:0]  sb_set_addr,
  output logic [31:0] busy,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  input  logic [4:0]  q_addr1,
  output logic        q_hit1,
  output logic [31:0] q_data1,
  input  logic [4:0]  q_addr2,
  output logic        q_hit2,
  output logic [31:0] q_data2
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Handshake: a transfer on a port happens in any cycle where its valid and ready are both high;
  // ready never depends on the same port's data, and a refused requester simply holds its request.

  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] busy_q, busy_d;

  logic starve;
  logic a_xfer;
  logic b_xfer;

  always_comb begin
    starve  = (cnt_q == LIMIT);
    a_ready = !(starve && b_valid);
    b_ready = !a_valid || starve;
    a_xfer  = a_valid && a_ready;
    b_xfer  = b_valid && b_ready;
  end

  always_comb begin
    cnt_d = 4'd0;
    if (b_valid && !b_ready) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 4'd1;
    end
  end

  // Writes to r0 are accepted but never reach the rf.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (a_xfer) begin
      we_d    = (a_waddr != 5'd0);
      waddr_d = a_waddr;
      wdata_d = a_wdata;
    end else if (b_xfer) begin
      we_d    = (b_waddr != 5'd0);
      waddr_d = b_waddr;
      wdata_d = b_wdata;
    end
  end

  // Clear lands together with the rf write; a same-cycle set of the same reg overrides it.
  always_comb begin
    busy_d = busy_q;
    if (b_xfer && b_waddr != 5'd0) begin
      busy_d[b_waddr] = 1'b0;
    end
    if (sb_set && sb_set_addr != 5'd0) begin
      busy_d[sb_set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
      busy_q  <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    we      = we_q;
    waddr   = waddr_q;
    wdata   = wdata_q;
    busy    = busy_q;
    q_hit1  = we_q && (waddr_q == q_addr1) && (q_addr1 != 5'd0);
    q_hit2  = we_q && (waddr_q == q_addr2) && (q_addr2 != 5'd0);
    q_data1 = q_hit1 ? wdata_q : 32'd0;
    q_data2 = q_hit2 ? wdata_q : 32'd0;
  end

endmodule
